// File: rtl/bpfcap_mm_arbiter.sv
// Round-robin, burst-locked sharing of one Avalon-MM master port between the
// bpfcap packet reader (read bursts) and the capture writer (write bursts).
module bpfcap_mm_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  rd_address,
  input  logic [BURST_W-1:0] rd_burstcount,
  input  logic               rd_read,
  output logic               rd_waitrequest,
  output logic [DATA_W-1:0]  rd_readdata,
  output logic               rd_readdatavalid,
  input  logic [ADDR_W-1:0]  wr_address,
  input  logic [BURST_W-1:0] wr_burstcount,
  input  logic               wr_write,
  input  logic [DATA_W-1:0]  wr_writedata,
  output logic               wr_waitrequest,
  output logic [ADDR_W-1:0]  m_address,
  output logic [BURST_W-1:0] m_burstcount,
  output logic               m_read,
  output logic               m_write,
  output logic [DATA_W-1:0]  m_writedata,
  input  logic               m_waitrequest,
  input  logic [DATA_W-1:0]  m_readdata,
  input  logic               m_readdatavalid,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_CMD   = 2'd1,
    S_RD_DATA  = 2'd2,
    S_WR_BURST = 2'd3
  } state_t;

  localparam logic [BURST_W-1:0] ONE = BURST_W'(1'b1);

  state_t             r_state, w_state_nxt;
  logic [BURST_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_last_wr, w_last_wr_nxt;
  logic               r_wr_started, w_wr_started_nxt;
  logic [BURST_W-1:0] w_rd_len, w_wr_len;

  // A burstcount of zero means a single beat, never 2^BURST_W.
  function automatic logic [BURST_W-1:0] burst_len(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? ONE : bc;
  endfunction

  // Effective burst lengths of both requesters
  always_comb begin
    w_rd_len = burst_len(rd_burstcount);
    w_wr_len = burst_len(wr_burstcount);
  end

  // Next-state, beat counter and round-robin pointer
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_wr_nxt    = r_last_wr;
    w_wr_started_nxt = r_wr_started;
    case (r_state)
      S_IDLE: begin
        w_wr_started_nxt = 1'b0;
        if (rd_read && (!wr_write || r_last_wr)) begin
          w_state_nxt   = S_RD_CMD;
          w_last_wr_nxt = 1'b0;
        end else if (wr_write) begin
          w_state_nxt   = S_WR_BURST;
          w_last_wr_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_CMD: begin
        if (rd_read && !m_waitrequest) begin
          w_cnt_nxt   = w_rd_len;
          w_state_nxt = S_RD_DATA;
        end else begin
          w_state_nxt = S_RD_CMD;
        end
      end
      S_RD_DATA: begin
        if (m_readdatavalid) begin
          w_cnt_nxt   = r_cnt - ONE;
          w_state_nxt = (r_cnt == ONE) ? S_IDLE : S_RD_DATA;
        end else begin
          w_state_nxt = S_RD_DATA;
        end
      end
      S_WR_BURST: begin
        // The first accepted beat latches the count of beats still to come.
        if (wr_write && !m_waitrequest) begin
          if (!r_wr_started) begin
            w_cnt_nxt        = w_wr_len - ONE;
            w_wr_started_nxt = 1'b1;
            w_state_nxt      = (w_wr_len == ONE) ? S_IDLE : S_WR_BURST;
          end else begin
            w_cnt_nxt   = r_cnt - ONE;
            w_state_nxt = (r_cnt == ONE) ? S_IDLE : S_WR_BURST;
          end
        end else begin
          w_state_nxt = S_WR_BURST;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any burst in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_wr    <= 1'b1;
      r_wr_started <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_wr    <= w_last_wr_nxt;
      r_wr_started <= w_wr_started_nxt;
    end
  end

  // Master-port steering and requester handshakes
  always_comb begin
    m_address        = rd_address;
    m_burstcount     = rd_burstcount;
    m_read           = 1'b0;
    m_write          = 1'b0;
    m_writedata      = wr_writedata;
    rd_waitrequest   = 1'b1;
    wr_waitrequest   = 1'b1;
    rd_readdatavalid = 1'b0;
    rd_readdata      = m_readdata;
    busy             = (r_state != S_IDLE);
    case (r_state)
      S_RD_CMD: begin
        m_read         = rd_read;
        rd_waitrequest = m_waitrequest;
      end
      S_RD_DATA: begin
        rd_readdatavalid = m_readdatavalid;
      end
      S_WR_BURST: begin
        m_address      = wr_address;
        m_burstcount   = wr_burstcount;
        m_write        = wr_write;
        wr_waitrequest = m_waitrequest;
      end
      default: begin
        m_read = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bpfcap_mm_arbiter.sv
// Bench for bpfcap_mm_arbiter: requester tasks, an Avalon slave model and a
// transaction-level reference model of grant order and burst data.
module tb_bpfcap_mm_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] rd_address = '0;
  logic [BW-1:0] rd_burstcount = '0;
  logic          rd_read = 1'b0;
  logic [AW-1:0] wr_address = '0;
  logic [BW-1:0] wr_burstcount = '0;
  logic          wr_write = 1'b0;
  logic [DW-1:0] wr_writedata = '0;
  logic          m_waitrequest = 1'b0;
  logic [DW-1:0] m_readdata = '0;
  logic          m_readdatavalid = 1'b0;
  logic          rd_waitrequest, rd_readdatavalid, wr_waitrequest;
  logic [DW-1:0] rd_readdata, m_writedata;
  logic [AW-1:0] m_address;
  logic [BW-1:0] m_burstcount;
  logic          m_read, m_write, busy;

  always #5 clk = ~clk;

  bpfcap_mm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk(clk), .reset(reset),
    .rd_address(rd_address), .rd_burstcount(rd_burstcount), .rd_read(rd_read),
    .rd_waitrequest(rd_waitrequest), .rd_readdata(rd_readdata),
    .rd_readdatavalid(rd_readdatavalid),
    .wr_address(wr_address), .wr_burstcount(wr_burstcount), .wr_write(wr_write),
    .wr_writedata(wr_writedata), .wr_waitrequest(wr_waitrequest),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read),
    .m_write(m_write), .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: returns rd_base+i for beat i of each read, logs write beats
  logic [DW-1:0] rq[$];
  logic [DW-1:0] wlog[$];
  logic [DW-1:0] rd_base = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [BW-1:0] cmd_bc = '0;
  bit rand_mode = 1'b0, slave_pause = 1'b0, stall_first = 1'b0;
  int rd_cmds = 0, m_rd_cycles = 0, wstall = 0;

  always @(posedge clk) begin
    int n;
    if (m_read === 1'b1) m_rd_cycles++;
    if (m_read === 1'b1 && m_waitrequest == 1'b0) begin
      n = (m_burstcount == '0) ? 1 : int'(m_burstcount);
      for (int i = 0; i < n; i++) rq.push_back(rd_base + DW'(i));
      rd_cmds++;
      cmd_addr = m_address;
      cmd_bc   = m_burstcount;
    end
    if (m_write === 1'b1 && m_waitrequest == 1'b1) begin
      wstall++;
      stall_first = 1'b0;
    end
    if (m_write === 1'b1 && m_waitrequest == 1'b0) wlog.push_back(m_writedata);
    #1;
    if (!slave_pause && rq.size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
      m_readdata      = rq.pop_front();
      m_readdatavalid = 1'b1;
    end else begin
      m_readdata      = $urandom;
      m_readdatavalid = 1'b0;
    end
    m_waitrequest = rand_mode ? ($urandom_range(0, 2) == 0) : stall_first;
  end

  // Requester-side monitor: delivered read beats, burst start side, idle gaps
  logic [DW-1:0] rd_got[$];
  bit glog[$];
  int gaps[$];
  bit prev_busy = 1'b0;
  int idle_run = 0;

  always @(negedge clk) begin
    if (rd_readdatavalid === 1'b1) rd_got.push_back(rd_readdata);
    if (busy === 1'b1 && !prev_busy) begin
      glog.push_back(m_write === 1'b1);
      gaps.push_back(idle_run);
    end
    idle_run  = (busy === 1'b1) ? 0 : idle_run + 1;
    prev_busy = (busy === 1'b1);
  end

  // Reference arbitration: both requesting -> opposite of last grant; returns 1 for WR
  bit model_last_wr = 1'b1;
  function automatic bit model_grant_wr(input bit r, input bit w);
    bit g;
    g = (r && w) ? !model_last_wr : w;
    model_last_wr = g;
    return g;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_last_wr = 1'b1;
  endtask

  task automatic rd_xact(input logic [AW-1:0] a, input logic [BW-1:0] bc, input logic [DW-1:0] base);
    int n;
    bit ok;
    n = (bc == '0) ? 1 : int'(bc);
    rd_got.delete();
    rd_base = base; rd_address = a; rd_burstcount = bc; rd_read = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      ok = (rd_waitrequest === 1'b0);
      @(negedge clk);
    end
    rd_read = 1'b0;
    check_value("rd_cmd_accept", 64'(ok), 64'd1);
    for (int t = 0; t < 200 && rd_got.size() < n; t++) begin
      @(negedge clk);
      #1;
    end
    check_value("rd_beat_count", 64'(rd_got.size()), 64'(n));
    for (int i = 0; i < n && i < rd_got.size(); i++)
      check_value("rd_beat_data", 64'(rd_got[i]), 64'(base + DW'(i)));
  endtask

  task automatic wr_xact(input logic [AW-1:0] a, input logic [BW-1:0] bc, input logic [DW-1:0] dq[$]);
    int n;
    bit ok;
    n = (bc == '0) ? 1 : int'(bc);
    wlog.delete();
    wr_address = a; wr_burstcount = bc;
    for (int b = 0; b < n; b++) begin
      wr_writedata = dq[b]; wr_write = 1'b1; ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
        ok = (wr_waitrequest === 1'b0);
        @(negedge clk);
      end
      check_value("wr_beat_accept", 64'(ok), 64'd1);
    end
    wr_write = 1'b0;
    check_value("wr_handshakes", 64'(wlog.size()), 64'(n));
    for (int i = 0; i < n && i < wlog.size(); i++)
      check_value("wr_beat_data", 64'(wlog[i]), 64'(dq[i]));
  endtask

  initial begin
    logic [DW-1:0] wd[$];
    logic [BW-1:0] bc_r, bc_w;
    bit ok, rdreq, wrreq, first_wr;
    bit exp_g[3];
    int stray, kind;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_m_read", 64'(m_read), 64'd0);
    check_value("rst_m_write", 64'(m_write), 64'd0);
    check_value("rst_rd_wait", 64'(rd_waitrequest), 64'd1);
    check_value("rst_wr_wait", 64'(wr_waitrequest), 64'd1);
    check_value("rst_busy", 64'(busy), 64'd0);
    check_value("rst_rd_valid", 64'(rd_readdatavalid), 64'd0);
    reset = 1'b1;
    model_last_wr = 1'b1;
    @(negedge clk);

    // Single read burst of 4
    m_rd_cycles = 0; rd_cmds = 0;
    void'(model_grant_wr(1'b1, 1'b0));
    rd_xact(32'h20, 16'd4, 32'd10);
    check_value("rd_cmd_count", 64'(rd_cmds), 64'd1);
    check_value("rd_cmd_addr", 64'(cmd_addr), 64'h20);
    check_value("rd_cmd_burst", 64'(cmd_bc), 64'd4);
    check_value("rd_cmd_cycles", 64'(m_rd_cycles), 64'd1);
    @(negedge clk);
    check_value("rd_idle_after_last", 64'(busy), 64'd0);

    // Write burst of 2 with a one-cycle stall on the first beat
    wstall = 0; stall_first = 1'b1;
    wd.delete(); wd.push_back(32'hA); wd.push_back(32'hB);
    void'(model_grant_wr(1'b0, 1'b1));
    wr_xact(32'h28, 16'd2, wd);
    check_value("wr_stall_cycles", 64'(wstall), 64'd1);
    check_value("wr_idle_after_last", 64'(busy), 64'd0);

    // Both requesting continuously after reset
    do_reset();
    glog.delete(); gaps.delete();
    exp_g[0] = model_grant_wr(1'b1, 1'b1);
    exp_g[1] = model_grant_wr(1'b1, 1'b1);
    exp_g[2] = model_grant_wr(1'b1, 1'b0);
    wd.delete(); wd.push_back(32'h1);
    fork
      begin
        rd_xact(32'h100, 16'd2, 32'h500);
        rd_xact(32'h200, 16'd1, 32'h600);
      end
      wr_xact(32'h300, 16'd1, wd);
    join
    repeat (2) @(negedge clk);
    check_value("rr_grant_count", 64'(glog.size()), 64'd3);
    for (int i = 0; i < 3 && i < glog.size(); i++) check_value("rr_grant_side", 64'(glog[i]), 64'(exp_g[i]));
    for (int i = 1; i < 3 && i < gaps.size(); i++) check_value("rr_idle_gap", 64'(gaps[i]), 64'd1);

    // Reset in the middle of a read burst; stray beats must be dropped
    rd_got.delete(); rd_base = 32'h700; rd_address = 32'h40; rd_burstcount = 16'd4; rd_read = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      ok = (rd_waitrequest === 1'b0);
      @(negedge clk);
    end
    rd_read = 1'b0;
    check_value("mid_rst_accept", 64'(ok), 64'd1);
    for (int t = 0; t < 200 && rd_got.size() < 2; t++) begin
      @(negedge clk);
      #1;
    end
    slave_pause = 1'b1; reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; model_last_wr = 1'b1; slave_pause = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd_readdatavalid !== 1'b0 || busy !== 1'b0) stray++;
    end
    check_value("mid_rst_stray", 64'(stray), 64'd0);
    check_value("mid_rst_beats", 64'(rd_got.size()), 64'd2);
    check_value("mid_rst_slave_drained", 64'(rq.size()), 64'd0);

    // Write burstcount 0 is one beat, then a normal read
    wd.delete(); wd.push_back(32'hC0FFEE);
    void'(model_grant_wr(1'b0, 1'b1));
    wr_xact(32'h80, 16'd0, wd);
    check_value("bc0_idle", 64'(busy), 64'd0);
    void'(model_grant_wr(1'b1, 1'b0));
    rd_xact(32'h90, 16'd3, 32'h1000);

    // Randomized episodes against the reference model
    rand_mode = 1'b1;
    for (int ep = 0; ep < 40 && n_err < 20; ep++) begin
      repeat (2) @(negedge clk);
      kind  = int'($urandom_range(0, 2));
      rdreq = (kind != 1);
      wrreq = (kind != 0);
      bc_r  = BW'($urandom_range(0, 5));
      bc_w  = BW'($urandom_range(0, 5));
      wd.delete();
      for (int i = 0; i < 6; i++) wd.push_back($urandom);
      first_wr = model_grant_wr(rdreq, wrreq);
      if (rdreq && wrreq) void'(model_grant_wr(first_wr, !first_wr));
      glog.delete();
      fork
        if (rdreq) rd_xact($urandom, bc_r, $urandom);
        if (wrreq) wr_xact($urandom, bc_w, wd);
      join
      repeat (2) @(negedge clk);
      check_value("rand_grant_count", 64'(glog.size()), 64'(int'(rdreq) + int'(wrreq)));
      if (glog.size() > 0) check_value("rand_first_grant", 64'(glog[0]), 64'(first_wr));
    end
    rand_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
